// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xorn_pipe.sv
// Pipelined WIDTH-bit XOR (parity) reduction with optional inversion and a
// running-parity accumulator; STAGES register levels, valid carried alongside.
module gf180mcu_fd_sc_mcu7t5v0__xorn_pipe #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STAGES        = 2,
  parameter logic        ACC_RESET_VAL = 1'b0
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] A,
  input  logic             VLD_I,
  input  logic             INV,
  input  logic             ACC_EN,
  input  logic             CLR,
  output logic             Z,
  output logic             VLD_O,
  output logic             ACC_Z
);

  if (WIDTH < 2 || WIDTH > 64 || STAGES < 1 || STAGES > 4 || STAGES > $clog2(WIDTH)) begin : g_bad_param
    $error("xorn_pipe: illegal WIDTH/STAGES combination");
  end

  // Stage 1 holds 2**(STAGES-1) chunk parities; each later level halves the count,
  // and the last level (the output register) takes the final pair plus INV.
  localparam int unsigned NP0 = 32'd1 << (STAGES - 1);
  localparam int unsigned CH  = (WIDTH + NP0 - 1) / NP0;

  logic [NP0*CH-1:0] w_a_pad;
  logic [NP0-1:0]    w_leaf;

  always_comb begin
    w_a_pad            = '0;
    w_a_pad[WIDTH-1:0] = A;
    for (int unsigned i = 0; i < NP0; i++) begin
      w_leaf[i] = ^w_a_pad[i*CH +: CH];
    end
  end

  for (genvar l = 0; l < STAGES - 1; l++) begin : g_lvl
    localparam int unsigned NP = NP0 >> l;

    logic [NP-1:0] w_in;
    logic [NP-1:0] r_part;
    logic          w_vld, w_inv, w_acc, w_clr;
    logic          r_vld, r_inv, r_acc, r_clr;

    if (l == 0) begin : g_head
      always_comb begin
        w_in  = w_leaf;
        w_vld = VLD_I;
        w_inv = INV;
        w_acc = ACC_EN;
        w_clr = CLR;
      end
    end else begin : g_body
      always_comb begin
        w_in = '0;
        for (int unsigned i = 0; i < NP; i++) begin
          w_in[i] = g_lvl[l-1].r_part[2*i] ^ g_lvl[l-1].r_part[2*i+1];
        end
        w_vld = g_lvl[l-1].r_vld;
        w_inv = g_lvl[l-1].r_inv;
        w_acc = g_lvl[l-1].r_acc;
        w_clr = g_lvl[l-1].r_clr;
      end
    end

    always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
        r_part <= '0;
        r_vld  <= 1'b0;
        r_inv  <= 1'b0;
        r_acc  <= 1'b0;
        r_clr  <= 1'b0;
      end else begin
        r_part <= w_in;
        r_vld  <= w_vld;
        r_inv  <= w_inv;
        r_acc  <= w_acc;
        r_clr  <= w_clr;
      end
    end
  end

  logic w_fin_x, w_fin_vld, w_fin_inv, w_fin_acc, w_fin_clr;

  if (STAGES == 1) begin : g_direct
    always_comb begin
      w_fin_x   = w_leaf[0];
      w_fin_vld = VLD_I;
      w_fin_inv = INV;
      w_fin_acc = ACC_EN;
      w_fin_clr = CLR;
    end
  end else begin : g_tail
    always_comb begin
      w_fin_x   = ^g_lvl[STAGES-2].r_part;
      w_fin_vld = g_lvl[STAGES-2].r_vld;
      w_fin_inv = g_lvl[STAGES-2].r_inv;
      w_fin_acc = g_lvl[STAGES-2].r_acc;
      w_fin_clr = g_lvl[STAGES-2].r_clr;
    end
  end

  logic r_z, r_vld, r_acc_z;
  logic w_z_nxt, w_acc_base, w_acc_nxt;

  always_comb begin
    w_z_nxt    = w_fin_x ^ w_fin_inv;
    w_acc_base = w_fin_clr ? ACC_RESET_VAL : r_acc_z;
    w_acc_nxt  = w_acc_base ^ (w_fin_acc & w_z_nxt);
  end

  // Z and the accumulator only move on valid words, so bubbles (and any CLR
  // riding on them) leave both untouched.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_z     <= 1'b0;
      r_vld   <= 1'b0;
      r_acc_z <= ACC_RESET_VAL;
    end else begin
      r_vld <= w_fin_vld;
      if (w_fin_vld) begin
        r_z     <= w_z_nxt;
        r_acc_z <= w_acc_nxt;
      end
    end
  end

  always_comb begin
    Z     = r_z;
    VLD_O = r_vld;
    ACC_Z = r_acc_z;
  end

`ifndef FUNCTIONAL
  specify
    (CLK => Z)     = (1.0, 1.0);
    (CLK => VLD_O) = (1.0, 1.0);
    (CLK => ACC_Z) = (1.0, 1.0);
    (RN => Z)      = (1.0, 1.0);
    (RN => VLD_O)  = (1.0, 1.0);
    (RN => ACC_Z)  = (1.0, 1.0);
    $setuphold(posedge CLK, A, 1.0, 1.0);
    $setuphold(posedge CLK, INV, 1.0, 1.0);
    $setuphold(posedge CLK, VLD_I, 1.0, 1.0);
    $setuphold(posedge CLK, ACC_EN, 1.0, 1.0);
    $setuphold(posedge CLK, CLR, 1.0, 1.0);
    $recrem(posedge RN, posedge CLK, 1.0, 1.0);
  endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__xorn_pipe.sv
// Bench for the pipelined parity cell: scripted scenarios on the 8-bit/2-stage
// instance, then random traffic on 2/1, 8/2 and 64/4 against a queue-based model.
module tb_gf180mcu_fd_sc_mcu7t5v0__xorn_pipe;

  logic CLK = 1'b0;
  logic rn  = 1'b1;
  always #5 CLK = ~CLK;

  logic [1:0]  a2;  logic vi2, inv2, acc2, clr2, z2, vo2, az2;
  logic [7:0]  a8;  logic vi8, inv8, acc8, clr8, z8, vo8, az8;
  logic [63:0] a64; logic vi64, inv64, acc64, clr64, z64, vo64, az64;

  gf180mcu_fd_sc_mcu7t5v0__xorn_pipe #(.WIDTH(2), .STAGES(1), .ACC_RESET_VAL(1'b0)) u_d2 (
    .CLK(CLK), .RN(rn), .A(a2), .VLD_I(vi2), .INV(inv2), .ACC_EN(acc2), .CLR(clr2),
    .Z(z2), .VLD_O(vo2), .ACC_Z(az2));

  gf180mcu_fd_sc_mcu7t5v0__xorn_pipe #(.WIDTH(8), .STAGES(2), .ACC_RESET_VAL(1'b0)) u_d8 (
    .CLK(CLK), .RN(rn), .A(a8), .VLD_I(vi8), .INV(inv8), .ACC_EN(acc8), .CLR(clr8),
    .Z(z8), .VLD_O(vo8), .ACC_Z(az8));

  gf180mcu_fd_sc_mcu7t5v0__xorn_pipe #(.WIDTH(64), .STAGES(4), .ACC_RESET_VAL(1'b1)) u_d64 (
    .CLK(CLK), .RN(rn), .A(a64), .VLD_I(vi64), .INV(inv64), .ACC_EN(acc64), .CLR(clr64),
    .Z(z64), .VLD_O(vo64), .ACC_Z(az64));

  // Row of a scripted table: inputs {inv,vld,acc,clr}, expected {z,vld_o,acc_z}.
  typedef struct packed {
    logic [7:0] a;
    logic inv, vld, acc, clr;
    logic ez, evo, eacc;
  } step_t;

  typedef struct {
    logic vld, z, acc, clr;
  } rec_t;

  int   checks   = 0;
  int   failures = 0;
  rec_t pipe [3][$];
  logic mz [3];
  logic mvo [3];
  logic macc [3];
  int   lat [3]  = '{1, 2, 4};
  logic rstv [3] = '{1'b0, 1'b0, 1'b1};

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_all;
    a2 = '0;  vi2 = 1'b0;  inv2 = 1'b0;  acc2 = 1'b0;  clr2 = 1'b0;
    a8 = '0;  vi8 = 1'b0;  inv8 = 1'b0;  acc8 = 1'b0;  clr8 = 1'b0;
    a64 = '0; vi64 = 1'b0; inv64 = 1'b0; acc64 = 1'b0; clr64 = 1'b0;
  endtask

  task automatic drive8(input step_t s);
    a8 = s.a; inv8 = s.inv; vi8 = s.vld; acc8 = s.acc; clr8 = s.clr;
  endtask

  function automatic logic [2:0] obs(input int d);
    case (d)
      0:       return {z2, vo2, az2};
      1:       return {z8, vo8, az8};
      default: return {z64, vo64, az64};
    endcase
  endfunction

  // Spec-level model: each instance is a STAGES-deep delay of accepted words.
  function automatic void model_edge(input int d);
    rec_t r;
    if (pipe[d].size() >= lat[d]) begin
      r = pipe[d].pop_front();
      mvo[d] = r.vld;
      if (r.vld) begin
        mz[d]   = r.z;
        macc[d] = (r.clr ? rstv[d] : macc[d]) ^ (r.acc & r.z);
      end
    end else begin
      mvo[d] = 1'b0;
    end
  endfunction

  task automatic test_reset;
    idle_all();
    rn = 1'b1;
    #1 rn = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs(d) !== {2'b00, rstv[d]}) begin
        failures++;
        $display("FAIL reset_assert d%0d got=%b exp=%b", d, obs(d), {2'b00, rstv[d]});
      end
    end
    repeat (2) tick();
    rn = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs(d) !== {2'b00, rstv[d]}) begin
        failures++;
        $display("FAIL reset_release d%0d got=%b exp=%b", d, obs(d), {2'b00, rstv[d]});
      end
    end
  endtask

  task automatic test_basic_parity;
    step_t t [3];
    t = '{ {8'hB5, 4'b0100, 3'b110},
           {8'h3C, 4'b0100, 3'b010},
           {8'h3C, 4'b1100, 3'b110} };
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) drive8(t[i]); else idle_all();
      tick();
      if (i > 0) begin
        checks++;
        if (obs(1) !== {t[i-1].ez, t[i-1].evo, t[i-1].eacc}) begin
          failures++;
          $display("FAIL basic_parity word%0d got=%b exp=%b", i-1, obs(1),
                   {t[i-1].ez, t[i-1].evo, t[i-1].eacc});
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    step_t t [4];
    t = '{ {8'h01, 4'b0100, 3'b110},
           {8'h03, 4'b0100, 3'b010},
           {8'h07, 4'b0100, 3'b110},
           {8'hFF, 4'b0000, 3'b100} };
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) drive8(t[i]); else idle_all();
      tick();
      if (i > 0) begin
        checks++;
        if (obs(1) !== {t[i-1].ez, t[i-1].evo, t[i-1].eacc}) begin
          failures++;
          $display("FAIL back_to_back word%0d got=%b exp=%b", i-1, obs(1),
                   {t[i-1].ez, t[i-1].evo, t[i-1].eacc});
        end
      end
    end
  endtask

  task automatic test_accumulate;
    step_t t [4];
    t = '{ {8'h01, 4'b0110, 3'b111},
           {8'h03, 4'b0110, 3'b011},
           {8'h07, 4'b0110, 3'b110},
           {8'hFF, 4'b0100, 3'b010} };
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) drive8(t[i]); else idle_all();
      tick();
      if (i > 0) begin
        checks++;
        if (obs(1) !== {t[i-1].ez, t[i-1].evo, t[i-1].eacc}) begin
          failures++;
          $display("FAIL accumulate word%0d got=%b exp=%b", i-1, obs(1),
                   {t[i-1].ez, t[i-1].evo, t[i-1].eacc});
        end
      end
    end
  endtask

  task automatic test_clear;
    step_t t [6];
    t = '{ {8'h01, 4'b0110, 3'b111},
           {8'h01, 4'b0111, 3'b111},
           {8'h00, 4'b0101, 3'b010},
           {8'h01, 4'b0110, 3'b111},
           {8'hFF, 4'b0011, 3'b101},
           {8'h00, 4'b0100, 3'b011} };
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) drive8(t[i]); else idle_all();
      tick();
      if (i > 0) begin
        checks++;
        if (obs(1) !== {t[i-1].ez, t[i-1].evo, t[i-1].eacc}) begin
          failures++;
          $display("FAIL clear word%0d got=%b exp=%b", i-1, obs(1),
                   {t[i-1].ez, t[i-1].evo, t[i-1].eacc});
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    drive8({8'h01, 4'b0100, 3'b000});
    tick();
    drive8({8'h07, 4'b0110, 3'b000});
    tick();
    checks++;
    if (obs(1) !== 3'b111) begin
      failures++;
      $display("FAIL reset_mid_pre got=%b exp=%b", obs(1), 3'b111);
    end
    #2 rn = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs(d) !== {2'b00, rstv[d]}) begin
        failures++;
        $display("FAIL reset_mid_async d%0d got=%b exp=%b", d, obs(d), {2'b00, rstv[d]});
      end
    end
    #1 rn = 1'b1;
    idle_all();
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs(d) !== {2'b00, rstv[d]}) begin
          failures++;
          $display("FAIL reset_mid_drop d%0d cyc%0d got=%b exp=%b", d, c, obs(d), {2'b00, rstv[d]});
        end
      end
    end
  endtask

  task automatic test_random_sweep;
    logic [63:0] w;
    logic v, iv, ac, cl;
    for (int d = 0; d < 3; d++) begin
      pipe[d].delete();
      mz[d]   = 1'b0;
      mvo[d]  = 1'b0;
      macc[d] = rstv[d];
    end
    for (int c = 0; c < 1004; c++) begin
      for (int d = 0; d < 3; d++) begin
        w  = {$urandom, $urandom};
        v  = (c < 1000) && ($urandom_range(0, 9) != 0);
        iv = 1'($urandom_range(0, 1));
        ac = 1'($urandom_range(0, 1));
        cl = ($urandom_range(0, 15) == 0);
        case (d)
          0: begin
            a2 = w[1:0]; vi2 = v; inv2 = iv; acc2 = ac; clr2 = cl;
            pipe[0].push_back('{v, 1'($countones(w[1:0]) % 2) ^ iv, ac, cl});
          end
          1: begin
            a8 = w[7:0]; vi8 = v; inv8 = iv; acc8 = ac; clr8 = cl;
            pipe[1].push_back('{v, 1'($countones(w[7:0]) % 2) ^ iv, ac, cl});
          end
          default: begin
            a64 = w; vi64 = v; inv64 = iv; acc64 = ac; clr64 = cl;
            pipe[2].push_back('{v, 1'($countones(w) % 2) ^ iv, ac, cl});
          end
        endcase
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        model_edge(d);
        checks++;
        if (obs(d) !== {mz[d], mvo[d], macc[d]}) begin
          failures++;
          $display("FAIL random d%0d cyc%0d got=%b exp=%b", d, c, obs(d), {mz[d], mvo[d], macc[d]});
        end
      end
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_basic_parity();
    test_back_to_back();
    test_accumulate();
    test_clear();
    test_reset_mid();
    test_random_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
